// File: rtl/cla_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial add/subtract engine.
package cla_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seqState_e;

  function automatic int nibbleCount(input int width);
    return width / NIBBLE_W;
  endfunction

  // A single-nibble operand still needs a 1-bit index register.
  function automatic int indexWidth(input int width);
    return (nibbleCount(width) > 1) ? $clog2(nibbleCount(width)) : 1;
  endfunction

endpackage

// File: rtl/cla_adder.sv
// Existing 4-bit carry-lookahead adder reused by the nibble-serial engine.
module cla_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] S,
  output logic       cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // Every carry is flattened from generate/propagate terms so none ripples.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign S    = w_p ^ w_c[3:0];
  assign cout = w_c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit add/subtract built by stepping one 4-bit CLA across the operands,
// LSB nibble first, with the ripple carry held in a register between steps.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = nibbleCount(WIDTH);
  localparam int KW = indexWidth(WIDTH);
  localparam logic [KW-1:0] LAST_K = KW'(N - 1);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_widthCheck
    $error("cla_seq_adder: WIDTH must be a positive multiple of 4");
  end

  seqState_e        r_state;
  logic [KW-1:0]    r_k;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_overflow;
  logic             r_inReady;
  logic             r_outValid;

  logic [NIBBLE_W-1:0] w_aNib;
  logic [NIBBLE_W-1:0] w_bNib;
  logic [NIBBLE_W-1:0] w_s;
  logic                w_cout;
  logic [WIDTH-1:0]    w_nibMask;
  logic [WIDTH-1:0]    w_sumNext;
  logic                w_msbCarryIn;

  assign w_aNib = NIBBLE_W'(r_a >> {r_k, 2'b00});
  assign w_bNib = NIBBLE_W'(r_b >> {r_k, 2'b00});

  cla_adder u_claAdder (
    .A    (w_aNib),
    .B    (w_bNib),
    .cin  (r_carry),
    .S    (w_s),
    .cout (w_cout)
  );

  assign w_nibMask = WIDTH'(4'hF) << {r_k, 2'b00};
  assign w_sumNext = (r_sum & ~w_nibMask) | (WIDTH'(w_s) << {r_k, 2'b00});

  // Only meaningful on the last nibble, where w_s[3] lands in the result MSB.
  assign w_msbCarryIn = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_s[NIBBLE_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_carry    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction folds into addition: A + ~B + ~borrow.
            r_a       <= a;
            r_b       <= sub ? ~b : b;
            r_carry   <= sub ? ~cin : cin;
            r_k       <= '0;
            r_inReady <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_sum   <= w_sumNext;
          r_carry <= w_cout;
          r_k     <= r_k + KW'(1);
          if (r_k == LAST_K) begin
            r_cout     <= w_cout;
            r_overflow <= w_msbCarryIn ^ w_cout;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder at WIDTH = 16: directed cases plus a
// randomized sweep against an integer-arithmetic reference model.
module tb_cla_seq_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int checkCount = 0;
  int errorCount = 0;
  int latency;

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Result as {overflow, cout, sum}, from plain unsigned and signed arithmetic.
  function automatic logic [17:0] refModel(input logic [15:0] ra, input logic [15:0] rb,
                                           input logic rs, input logic rc);
    logic [16:0] u;
    int          sa;
    int          sb;
    int          exact;
    logic        c;
    logic        ovf;
    sa = int'($signed(ra));
    sb = int'($signed(rb));
    if (!rs) begin
      u     = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      c     = u[16];
      exact = sa + sb + int'(rc);
    end else begin
      u     = {1'b0, ra} - {1'b0, rb} - {16'd0, rc};
      c     = ~u[16];
      exact = sa - sb - int'(rc);
    end
    ovf = (exact > 32767) || (exact < -32768);
    return {ovf, c, u[15:0]};
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0)
      checkOutput("readyValidExclusive", {31'd0, in_ready & out_valid}, 32'd0);
  end

  // Entered and left at posedge+1; runs one full operation through both handshakes.
  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb2,
                               input logic ts, input logic tc, input int preGap,
                               input int holdCycles, input bit scramble, input bit earlyReady);
    logic [17:0] expRes;
    int          w;
    repeat (preGap) begin
      @(posedge clk);
      #1;
    end
    a        = ta;
    b        = tb2;
    sub      = ts;
    cin      = tc;
    in_valid = 1'b1;
    w        = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!in_ready) checkOutput("acceptTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (scramble) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      sub = 1'($urandom);
      cin = 1'($urandom);
    end
    out_ready = earlyReady;
    latency   = 0;
    while (!out_valid && latency < 50) begin
      @(posedge clk);
      #1;
      latency++;
    end
    expRes = refModel(ta, tb2, ts, tc);
    checkOutput("latency", latency, 32'd4);
    checkOutput("sum", {16'd0, sum}, {16'd0, expRes[15:0]});
    checkOutput("cout", {31'd0, cout}, {31'd0, expRes[16]});
    checkOutput("overflow", {31'd0, overflow}, {31'd0, expRes[17]});
    if (!earlyReady) begin
      for (int i = 0; i < holdCycles; i++) begin
        @(posedge clk);
        #1;
        checkOutput("holdSum", {16'd0, sum}, {16'd0, expRes[15:0]});
        checkOutput("holdCout", {31'd0, cout}, {31'd0, expRes[16]});
        checkOutput("holdOverflow", {31'd0, overflow}, {31'd0, expRes[17]});
        checkOutput("holdOutValid", {31'd0, out_valid}, 32'd1);
        checkOutput("holdInReady", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("outValidAfterXfer", {31'd0, out_valid}, 32'd0);
    checkOutput("inReadyAfterXfer", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    cin       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOutValid", {31'd0, out_valid}, 32'd0);
    checkOutput("resetSum", {16'd0, sum}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("resetInReady", {31'd0, in_ready}, 32'd1);
    checkOutput("resetCout", {31'd0, cout}, 32'd0);
    checkOutput("resetOverflow", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1;

    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 0, 1'b0, 1'b1);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0);
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1);
    applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(16'h1357, 16'h2468, 1'b0, 1'b0, 0, 5, 1'b1, 1'b0);

    // Abort an operation while nibble 2 is in flight.
    a        = 16'hAAAA;
    b        = 16'h5555;
    sub      = 1'b0;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midResetSum", {16'd0, sum}, 32'd0);
    checkOutput("midResetCout", {31'd0, cout}, 32'd0);
    checkOutput("midResetOverflow", {31'd0, overflow}, 32'd0);
    checkOutput("midResetOutValid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("postResetInReady", {31'd0, in_ready}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("discardedOutValid", {31'd0, out_valid}, 32'd0);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 16 == 0) ra = 16'hFFFF;
      if (i % 16 == 1) rb = 16'h8000;
      if (i % 16 == 2) ra = 16'h7FFF;
      applyStimulus(ra, rb, i[1], i[0], $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle wide add/subtract unit that sequences the team's existing 4-bit carry-lookahead adder (`cla_adder`) over a WIDTH-bit operand pair, one nibble per clock, LSB first. Ripple carry is held in a register between nibbles. The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It is the shared arithmetic engine for datapaths wider than 4 bits that cannot afford a full-width adder.

## Interface
- `WIDTH`, default 16: operand/result width; must be a multiple of 4 and at least 4. Nibble count N = WIDTH/4.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand set valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  operand A (two's complement or unsigned).
- `b`  in  WIDTH  operand B.
- `sub`  in  1  0: A+B+cin; 1: A−B−cin (cin acts as borrow-in).
- `cin`  in  1  carry-in / borrow-in.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  WIDTH  result.
- `cout`  out  1  carry out of MSB (for sub: 1 = no borrow).
- `overflow`  out  1  signed overflow.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid`: capture `a`; capture `b` as `sub ? ~b : b`; set carry register to `sub ? ~cin : cin`; clear nibble index k to 0; go to RUN.
- **RUN**
  - `in_ready` = 0.
  - Drive `cla_adder` with A[4k+3:4k], B'[4k+3:4k] and the carry register.
  - At each edge, write S to `sum[4k+3:4k]`, load `cout` into the carry register, and increment k.
  - After nibble N−1, go to DONE.
- **DONE**
  - `out_valid` = 1.
  - `cout` = final carry.
  - `overflow` = carry-into-MSB XOR final carry. Carry-into-MSB = A[W−1] ^ B'[W−1] ^ sum[W−1].
  - Hold all outputs stable while `out_ready` = 0.
  - On `out_ready`, go to IDLE.
- Operand inputs are sampled only at acceptance. Changes to them during RUN or DONE are ignored.
- `sum`, `cout` and `overflow` are meaningful only while `out_valid` = 1. In IDLE they hold the last result. During RUN, `sum` changes nibble by nibble.
- `in_ready` and `out_valid` are never both 1.
- **Reset** (asynchronous, any state, including mid-RUN):
  - State goes to IDLE, k to 0, carry register to 0.
  - `sum` = 0, `cout` = 0, `overflow` = 0, `out_valid` = 0.
  - `in_ready` = 1 once `rst` deasserts. The in-flight operation is discarded.
- **Arithmetic:**
  - Add: {cout, sum} = A + B + cin, modulo 2^(WIDTH+1).
  - Sub: sum = (A − B − cin) mod 2^WIDTH, with cout = NOT borrow.
  - No saturation.
- **k width:** clog2(N), minimum 1 bit. Wrap-around is not possible, because k is reset on every acceptance.

## Timing
- Let E0 be the acceptance edge (`in_valid` & `in_ready`).
- **Latency:** nibble j is registered at edge E(j+1). The FSM enters DONE at edge EN, and `out_valid` is high in the cycle after EN. That is N cycles; 4 cycles for WIDTH = 16.
- **Result handshake:** the transfer occurs at the edge where `out_valid` & `out_ready`. `in_ready` rises in the following cycle.
- **Throughput:** one operation per N+2 cycles, assuming `out_ready` is held high.
- **Combinational paths:** the only one is through a single 4-bit `cla_adder` plus the carry mux. There is no input-to-output combinational path.

## Structure
- **Package `cla_seq_pkg`:**
  - FSM state enum (IDLE, RUN, DONE).
  - `NIBBLE_W` = 4.
  - Function computing N from WIDTH.
- **Sub-module:** exactly one instance of the existing `cla_adder` (4-bit: A, B, cin → S, cout). No other sub-modules.
- **Top-level elaboration check:** WIDTH % 4 == 0.

## Test plan
Test plan runs at WIDTH = 16.
1. Add with carry-out: a=0xFFFF, b=0x0001, sub=0, cin=0 → sum=0x0000, cout=1, overflow=0. `out_valid` rises exactly 4 cycles after acceptance.
2. Signed overflow: a=0x7FFF, b=0x0001, sub=0, cin=0 → sum=0x8000, cout=0, overflow=1.
3. Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0, overflow=0. Then a=0x1234, b=0x4321, sub=0, cin=1 → sum=0x5556, cout=0.
4. Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_valid`, `sum`, `cout` and `overflow` stay constant and `in_ready` stays 0. Change `a`/`b` during RUN → result is unaffected.
5. Reset mid-operation: assert `rst` during nibble 2 of 0xAAAA+0x5555 → outputs are all 0 and `in_ready`=1 after release. Next operation 0x8000+0x8000 → sum=0x0000, cout=1, overflow=1.
6. Randomized sweep: 1000 random operand sets covering all combinations of `sub` and `cin`, with random `in_valid`/`out_ready` gaps, checked against a behavioral model. Error counter must be 0.
